instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Fetch controller sitting between the Program Counter, instruction memory and the execution unit. It issues a read request at the current PC value and latches the returned word into a single-entry instruction register (IR). It drives the PC's increment/load controls and handles taken branches by redirecting the PC and squashing stale fetches. It also supports halting.

Parameters:
AW, 16, address width (matches PC width)
DW, 16, instruction word width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
pc_out  in  AW  current PC value from Program Counter
pc_inc  out  1  PC increment strobe, combinational
pc_ld  out  1  PC load strobe, combinational, priority over pc_inc
pc_in  out  AW  PC load value (= br_target)
mem_rd_req  out  1  memory read request
mem_addr  out  AW  read address
mem_rd_ack  in  1  read acknowledge; mem_rd_data valid this cycle
mem_rd_data  in  DW  read data
ir_valid  out  1  IR holds a valid instruction
ir_out  out  DW  instruction word
ir_pc  out  AW  address the instruction was fetched from
ir_ready  in  1  execution unit accepts IR this cycle
br_taken  in  1  taken-branch pulse from execute
br_target  in  AW  branch target address
halt  in  1  level; stop issuing new fetches
fetch_cnt  out  16  count of instructions accepted by execute, wraps

Behaviour:
- States: S_IDLE (halted), S_REQ (request outstanding), S_FULL (IR valid), S_DROP (stale request outstanding).
- Reset (reset=0, async): state=S_REQ if halt=0 else S_IDLE. ir_valid=0, ir_out=0, ir_pc=0, fetch_cnt=0. Combinational outputs follow state.
- mem_rd_req=1 in S_REQ and S_DROP only. mem_addr=pc_out. A request is never withdrawn before ack; the PC does not change while the request is held, except via pc_ld in S_DROP. Ack may arrive in the same cycle as the request (zero-wait memory).
- pc_in=br_target at all times. pc_ld=br_taken in every state. pc_inc=1 only in S_REQ when mem_rd_ack=1 and br_taken=0.
- S_REQ, ack, no branch: on the edge, IR<=mem_rd_data, ir_pc<=pc_out, ir_valid<=1, and the PC increments. Next state is S_FULL.
- S_REQ, no ack, branch: next state S_DROP.
- S_REQ, ack and branch in the same cycle: data is discarded, the PC loads br_target, and the state stays S_REQ.
- S_FULL, ir_ready=1, br_taken=0: ir_valid<=0 and fetch_cnt+1 (wraps 0xFFFF->0). Next state is S_IDLE if halt=1, else S_REQ.
- S_FULL, br_taken=1: IR is flushed (ir_valid<=0), ir_ready is ignored and fetch_cnt is unchanged. Next state is S_REQ, or S_IDLE if halt=1.
- S_DROP: a further br_taken reloads the PC and the state stays S_DROP. On ack the data is discarded and pc_inc=0. Next state is S_REQ, or S_IDLE if halt=1. An ack coinciding with a branch behaves the same, with the new PC load taking effect.
- S_IDLE: no request. br_taken loads the PC. When halt=0, go to S_REQ next cycle.
- halt does not abort an outstanding request; a request in S_REQ completes into S_FULL.
- Throughput: with zero-wait memory and ir_ready held high, one instruction every 2 cycles.
- Reset mid-request: the request drops immediately. Memory must tolerate an abandoned request.

Decomposition:
- Shared package holds the state encoding constants (S_IDLE, S_REQ, S_FULL, S_DROP, 2-bit) and the AW/DW defaults shared with Program_Counter and the execution unit.
- No sub-module is needed. The IR and fetch_cnt registers stay inline with the FSM.

Test Plan:
- Reset, halt=0, zero-wait memory returning mem[a]=0x1000+a, ir_ready=1 -> IR sequence 0x1000,0x1001,0x1002 with ir_pc 0,1,2; pc_inc pulses every 2 cycles; fetch_cnt=3.
- Memory ack delayed 3 cycles -> mem_rd_req held high with mem_addr stable at 0x0005 for 4 cycles; exactly one pc_inc.
- br_taken=1, br_target=0x0040 while a request is outstanding with ack 2 cycles later -> pc_ld same cycle, returned word not latched (ir_valid stays 0), next mem_addr=0x0040.
- Branch to 0x0080 in S_FULL with ir_ready=1 the same cycle -> ir_valid=0 next cycle, fetch_cnt unchanged, next fetch at 0x0080.
- halt=1 asserted while in S_REQ -> request completes, IR consumed, then no mem_rd_req. halt=0 -> fetch resumes at the incremented PC.
- fetch_cnt preset near wrap by 0xFFFF accepts, one more accept -> fetch_cnt=0x0000. Assert reset=0 mid-request -> ir_valid=0, mem_rd_req=0 immediately.

Source files
------------

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: state encoding and the address/data
// widths used by the Program Counter and the execution unit.
package instr_fetch_ctrl_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_FULL = 2'd2,
      S_DROP = 2'd3
   } fetch_state_t;

   // Entry state: fetch immediately unless the core is held halted.
   function automatic fetch_state_t boot_state(input logic halt_i);
      fetch_state_t st;
      if (halt_i) begin
         st = S_IDLE;
      end else begin
         st = S_REQ;
      end
      return st;
   endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: issues reads at the PC, holds one instruction in the IR,
// drives PC increment/load and squashes fetches made stale by taken branches.
module instr_fetch_ctrl
   import instr_fetch_ctrl_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] pc_out,
   output logic          pc_inc,
   output logic          pc_ld,
   output logic [AW-1:0] pc_in,
   output logic          mem_rd_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_rd_ack,
   input  logic [DW-1:0] mem_rd_data,
   output logic          ir_valid,
   output logic [DW-1:0] ir_out,
   output logic [AW-1:0] ir_pc,
   input  logic          ir_ready,
   input  logic          br_taken,
   input  logic [AW-1:0] br_target,
   input  logic          halt,
   output logic [15:0]   fetch_cnt
);

   fetch_state_t  state_r;
   fetch_state_t  state_s;
   fetch_state_t  next_state_s;
   logic          boot_done_r;
   logic          pc_inc_s;
   logic          mem_rd_req_s;
   logic          capture_s;
   logic          accept_s;
   logic          flush_s;
   logic          ir_valid_r;
   logic [DW-1:0] ir_out_r;
   logic [AW-1:0] ir_pc_r;
   logic [15:0]   fetch_cnt_r;

   // Next-state and strobe decode; before the first edge after reset the
   // effective state tracks halt so the entry state never needs an async load.
   always_comb begin
      if (boot_done_r) begin
         state_s = state_r;
      end else begin
         state_s = boot_state(halt);
      end
      next_state_s = state_s;
      pc_inc_s     = 1'b0;
      mem_rd_req_s = 1'b0;
      capture_s    = 1'b0;
      accept_s     = 1'b0;
      flush_s      = 1'b0;
      case (state_s)
         S_IDLE: begin
            if (!halt) begin
               next_state_s = S_REQ;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_REQ: begin
            mem_rd_req_s = 1'b1;
            if (mem_rd_ack && !br_taken) begin
               pc_inc_s     = 1'b1;
               capture_s    = 1'b1;
               next_state_s = S_FULL;
            end else if (!mem_rd_ack && br_taken) begin
               next_state_s = S_DROP;
            end else begin
               next_state_s = S_REQ;
            end
         end
         S_FULL: begin
            if (br_taken) begin
               flush_s      = 1'b1;
               next_state_s = boot_state(halt);
            end else if (ir_ready) begin
               accept_s     = 1'b1;
               next_state_s = boot_state(halt);
            end else begin
               next_state_s = S_FULL;
            end
         end
         S_DROP: begin
            mem_rd_req_s = 1'b1;
            if (mem_rd_ack) begin
               next_state_s = boot_state(halt);
            end else begin
               next_state_s = S_DROP;
            end
         end
         default: begin
            next_state_s = boot_state(halt);
         end
      endcase
   end

   // Strobes are held off while reset is asserted so an abandoned request drops at once.
   assign mem_rd_req = mem_rd_req_s & reset;
   assign pc_inc     = pc_inc_s & reset;
   assign pc_ld      = br_taken & reset;
   assign pc_in      = br_target;
   assign mem_addr   = pc_out;
   assign ir_valid   = ir_valid_r;
   assign ir_out     = ir_out_r;
   assign ir_pc      = ir_pc_r;
   assign fetch_cnt  = fetch_cnt_r;

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= S_IDLE;
         boot_done_r <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         boot_done_r <= 1'b1;
      end
   end

   // Instruction register: load on a clean fetch, invalidate on accept or flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir_valid_r <= 1'b0;
         ir_out_r   <= '0;
         ir_pc_r    <= '0;
      end else if (capture_s) begin
         ir_valid_r <= 1'b1;
         ir_out_r   <= mem_rd_data;
         ir_pc_r    <= pc_out;
      end else if (accept_s || flush_s) begin
         ir_valid_r <= 1'b0;
      end else begin
         ir_valid_r <= ir_valid_r;
      end
   end

   // Count of instructions handed to execute; wraps naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt_r <= 16'h0000;
      end else if (accept_s) begin
         fetch_cnt_r <= fetch_cnt_r + 16'h0001;
      end else begin
         fetch_cnt_r <= fetch_cnt_r;
      end
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: transaction-level reference model,
// bench-owned Program Counter and memory, directed scenarios plus random traffic.
module tb_instr_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pc_out;
   logic        pc_inc, pc_ld, mem_rd_req, ir_valid;
   logic [15:0] pc_in, mem_addr, ir_out, ir_pc, fetch_cnt;
   logic        mem_rd_ack, ir_ready, br_taken, halt;
   logic [15:0] mem_rd_data, br_target;

   always #5 clk = ~clk;

   instr_fetch_ctrl #(.AW(16), .DW(16)) dut (
      .clk(clk), .reset(reset), .pc_out(pc_out), .pc_inc(pc_inc), .pc_ld(pc_ld),
      .pc_in(pc_in), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
      .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .ir_valid(ir_valid),
      .ir_out(ir_out), .ir_pc(ir_pc), .ir_ready(ir_ready), .br_taken(br_taken),
      .br_target(br_target), .halt(halt), .fetch_cnt(fetch_cnt)
   );

   int checks = 0;
   int failures = 0;

   // reference model: what the fetch unit is doing, as plain flags
   bit          m_fetching, m_stale, m_full;
   logic [15:0] m_pc, m_ir, m_irpc, m_cnt;
   // bench memory and stimulus knobs
   bit          mem_busy;
   int          mem_wait;
   int          lat_fixed;
   int          br_pct, ready_pct, halt_pct;
   bit          halt_cmd, tgt_rand;
   logic [15:0] tgt_fixed, salt;
   // observations of the DUT
   int          inc_count, req5_cnt, req_count;
   bit          last_req, last_ld, last_valid, prev_valid, any_valid;
   logic [15:0] last_addr, last_cnt;
   logic [15:0] seen_ir[$];
   logic [15:0] seen_pc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      bit          exp_req, exp_inc, ack, br;
      logic [15:0] data;
      @(posedge clk);
      #1;
      pc_out = m_pc;
      if (halt_pct > 0) begin
         if ($urandom_range(99) < halt_pct) halt = ~halt;
      end else begin
         halt = halt_cmd;
      end
      br_taken  = ($urandom_range(99) < br_pct);
      br_target = tgt_rand ? 16'($urandom) : tgt_fixed;
      ir_ready  = ($urandom_range(99) < ready_pct);
      exp_req   = m_fetching;
      if (exp_req && !mem_busy) begin
         mem_busy = 1'b1;
         mem_wait = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(3));
      end
      mem_rd_ack  = exp_req && mem_busy && (mem_wait == 0);
      mem_rd_data = (16'h1000 + m_pc) ^ salt;
      ack  = mem_rd_ack;
      br   = br_taken;
      data = mem_rd_data;
      exp_inc = m_fetching && !m_stale && ack && !br;
      #1;
      check("mem_rd_req", mem_rd_req, exp_req);
      check("mem_addr", mem_addr, m_pc);
      check("pc_ld", pc_ld, br);
      check("pc_in", pc_in, br_target);
      check("pc_inc", pc_inc, exp_inc);
      check("ir_valid", ir_valid, m_full);
      check("ir_out", ir_out, m_ir);
      check("ir_pc", ir_pc, m_irpc);
      check("fetch_cnt", fetch_cnt, m_cnt);
      // observations for the directed scenarios
      if (pc_inc) inc_count++;
      if (mem_rd_req) req_count++;
      if (mem_rd_req && mem_addr == 16'h0005) req5_cnt++;
      if (ir_valid) any_valid = 1'b1;
      if (ir_valid && !prev_valid) begin
         seen_ir.push_back(ir_out);
         seen_pc.push_back(ir_pc);
      end
      prev_valid = ir_valid;
      last_req   = mem_rd_req;
      last_addr  = mem_addr;
      last_ld    = pc_ld;
      last_valid = ir_valid;
      last_cnt   = fetch_cnt;
      // advance the model across the coming edge
      if (m_fetching && !m_stale) begin
         if (ack && !br) begin
            m_full = 1'b1; m_fetching = 1'b0;
            m_ir = data; m_irpc = m_pc; m_pc = m_pc + 16'd1;
         end else if (br) begin
            m_pc = br_target;
            if (!ack) m_stale = 1'b1;
         end
      end else if (m_fetching) begin
         if (br) m_pc = br_target;
         if (ack) begin m_stale = 1'b0; m_fetching = !halt; end
      end else if (m_full) begin
         if (br) begin
            m_full = 1'b0; m_pc = br_target; m_fetching = !halt;
         end else if (ir_ready) begin
            m_full = 1'b0; m_cnt = m_cnt + 16'd1; m_fetching = !halt;
         end
      end else begin
         if (br) m_pc = br_target;
         m_fetching = !halt;
      end
      if (mem_busy) begin
         if (ack) mem_busy = 1'b0;
         else mem_wait--;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] cnt_b, a_pc;
      int n;
      reset = 1'b0; halt = 1'b0; br_taken = 1'b0; br_target = 16'h0; ir_ready = 1'b0;
      mem_rd_ack = 1'b0; mem_rd_data = 16'h0; pc_out = 16'h0;
      m_fetching = 1'b0; m_stale = 1'b0; m_full = 1'b0;
      m_pc = 16'h0; m_ir = 16'h0; m_irpc = 16'h0; m_cnt = 16'h0;
      mem_busy = 1'b0; mem_wait = 0; lat_fixed = 0;
      br_pct = 0; ready_pct = 100; halt_pct = 0; halt_cmd = 1'b0;
      tgt_rand = 1'b0; tgt_fixed = 16'h0; salt = 16'h0;
      inc_count = 0; req5_cnt = 0; req_count = 0; prev_valid = 1'b0; any_valid = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #2;
      check("rst_mem_rd_req", mem_rd_req, 1'b0);
      check("rst_ir_valid", ir_valid, 1'b0);
      check("rst_fetch_cnt", fetch_cnt, 16'h0000);
      check("rst_ir_out", ir_out, 16'h0000);
      check("rst_pc_inc", pc_inc, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      m_fetching = !halt;

      // zero-wait streaming: 0x1000, 0x1001, 0x1002
      repeat (6) step();
      check("seq_len", seen_ir.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < seen_ir.size()) begin
            check("seq_ir", seen_ir[i], 16'h1000 + 16'(i));
            check("seq_ir_pc", seen_pc[i], 16'(i));
         end
      end
      check("seq_pc_inc_count", inc_count, 3);
      step();
      check("seq_fetch_cnt", last_cnt, 16'h0003);

      // three-cycle memory latency at address 5
      repeat (3) step();
      lat_fixed = 3; req5_cnt = 0; inc_count = 0;
      repeat (6) step();
      check("slow_req_hold", req5_cnt, 4);
      check("slow_pc_inc_count", inc_count, 1);

      // branch while a request is outstanding
      lat_fixed = 2;
      for (n = 0; n < 50 && !(m_fetching && !m_stale && !mem_busy); n++) step();
      check("wait_fresh_req1", (m_fetching && !m_stale && !mem_busy), 1'b1);
      tgt_fixed = 16'h0040; br_pct = 100;
      step();
      check("drop_pc_ld", last_ld, 1'b1);
      br_pct = 0; any_valid = 1'b0;
      repeat (3) step();
      check("drop_no_ir", any_valid, 1'b0);
      check("drop_next_req", last_req, 1'b1);
      check("drop_next_addr", last_addr, 16'h0040);

      // branch in S_FULL with ir_ready high
      lat_fixed = 0;
      for (n = 0; n < 50 && !m_full; n++) step();
      check("wait_full", m_full, 1'b1);
      cnt_b = m_cnt; tgt_fixed = 16'h0080; br_pct = 100;
      step();
      br_pct = 0;
      step();
      check("flush_ir_valid", last_valid, 1'b0);
      check("flush_cnt_held", last_cnt, cnt_b);
      check("flush_next_req", last_req, 1'b1);
      check("flush_next_addr", last_addr, 16'h0080);

      // halt while a request is in flight
      lat_fixed = 1;
      for (n = 0; n < 50 && !(m_fetching && !m_stale && !mem_busy); n++) step();
      check("wait_fresh_req2", (m_fetching && !m_stale && !mem_busy), 1'b1);
      a_pc = m_pc; cnt_b = m_cnt; halt_cmd = 1'b1; any_valid = 1'b0;
      repeat (4) step();
      check("halt_ir_latched", any_valid, 1'b1);
      req_count = 0;
      repeat (4) step();
      check("halt_no_req", req_count, 0);
      check("halt_cnt", last_cnt, cnt_b + 16'd1);
      halt_cmd = 1'b0;
      repeat (2) step();
      check("resume_req", last_req, 1'b1);
      check("resume_addr", last_addr, a_pc + 16'd1);

      // randomized traffic
      lat_fixed = -1; br_pct = 10; ready_pct = 70; halt_pct = 4;
      tgt_rand = 1'b1; salt = 16'($urandom);
      repeat (3000) step();

      // counter wrap
      halt_pct = 0; halt_cmd = 1'b0; br_pct = 0; ready_pct = 100; lat_fixed = 0;
      step();
      force dut.fetch_cnt_r = 16'hFFFF;
      m_cnt = 16'hFFFF;
      #1;
      release dut.fetch_cnt_r;
      for (n = 0; n < 20 && m_cnt != 16'h0000; n++) step();
      check("wrap_reached", m_cnt, 16'h0000);
      step();
      check("wrap_fetch_cnt", last_cnt, 16'h0000);

      // reset in the middle of a request
      lat_fixed = 2;
      for (n = 0; n < 50 && !(m_fetching && !mem_busy); n++) step();
      check("wait_fresh_req3", (m_fetching && !mem_busy), 1'b1);
      step();
      reset = 1'b0; mem_rd_ack = 1'b0; br_taken = 1'b0;
      #1;
      check("midrst_mem_rd_req", mem_rd_req, 1'b0);
      check("midrst_ir_valid", ir_valid, 1'b0);
      check("midrst_fetch_cnt", fetch_cnt, 16'h0000);
      m_full = 1'b0; m_stale = 1'b0; m_fetching = 1'b0; m_cnt = 16'h0;
      m_ir = 16'h0; m_irpc = 16'h0; mem_busy = 1'b0; prev_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      m_fetching = !halt;
      lat_fixed = -1; br_pct = 10; ready_pct = 70;
      repeat (40) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
